data_mem_responder: RTL
=======================

// Module: data_mem_responder
// PURPOSE
// - Data-memory responder for the multi-cycle RISC core: services the readdmem/writedmem
//   strobes the main control FSM raises in MEM, on behalf of the LD/ST datapath.
// - Word-addressed internal RAM with configurable wait states.
// - Signals completion with a one-cycle ready pulse and flags illegal accesses on err.
// PARAMETERS
// - ADDR_W    10   word-address width; DEPTH = 2**ADDR_W 32-bit words
// - WAIT_CYC  1    wait-state cycles inserted before the access (0..15)
// PORTS
// - clk        in   1   system clock, all state updates on posedge
// - reset      in   1   asynchronous, active-low reset (asserted when 0)
// - readdmem   in   1   read strobe from control FSM, level, held several cycles
// - writedmem  in   1   write strobe from control FSM, level, held several cycles
// - addr       in   32  byte address (ALU output); word index = addr[ADDR_W+1:2]
// - wdata      in   32  store data (B register)
// - rdata      out  32  load data, feeds the LMD register
// - ready      out  1   one-cycle completion pulse
// - busy       out  1   high while a transaction is in progress (state != IDLE)
// - err        out  1   qualifies ready: access rejected
// BEHAVIOUR
// - Reset (reset==0, async): state=IDLE, rdata=0, ready=0, busy=0, err=0, wait counter=0,
//   strobe history=0. RAM contents are not reset. Reset mid-transaction aborts it;
//   a write is not committed unless ACCESS has already completed.
// - Request = rising edge of (readdmem|writedmem), using registered previous values.
//   Detected only in IDLE. A strobe held high never retriggers; it must fall and rise again.
// - FSM: IDLE -> WAIT (WAIT_CYC>0) or ACCESS (WAIT_CYC==0) on request.
//   - At that edge, latch op, addr and wdata.
//   - WAIT stays WAIT_CYC cycles (counter WAIT_CYC-1 down to 0), then ACCESS.
//   - ACCESS performs the access and goes to DONE. DONE goes to IDLE.
// - Timing: with the request sampled at edge E0, ready is high for exactly one cycle
//   starting at edge E0+WAIT_CYC+1.
//   - WAIT_CYC=1: ready rises at E2. WAIT_CYC=0: ready rises at E1.
// - Read: rdata <= RAM[idx] at the ACCESS edge. rdata holds until the next successful read.
// - Write: RAM[idx] <= latched wdata at the ACCESS edge.
// - Errors, each reported as err=1 in the same cycle as ready; err is 0 whenever ready is 0.
//   - Both strobes rising on the same edge.
//   - Word index >= DEPTH, i.e. addr[31:ADDR_W+2] != 0.
//   - Misalignment (see CONFIGURATION).
//   - On error: no RAM write, rdata unchanged; timing is identical to a normal access.
// - Strobes are ignored while busy. Address and data changes after the latch edge have no effect.
// CONFIGURATION
// - DMEM_ALIGN_CHK_EN defined: addr[1:0] != 2'b00 is an error (err=1, no access).
// - DMEM_ALIGN_CHK_EN undefined: addr[1:0] is ignored and the access uses the word index.
// TESTING
// - Store then load, WAIT_CYC=1.
//   - writedmem pulse: addr=0x10, wdata=0xDEADBEEF -> ready at E0+2, err=0.
//   - readdmem pulse: addr=0x10 -> rdata=0xDEADBEEF at ready.
// - Held strobe: readdmem high for 6 cycles -> exactly one ready pulse; busy high for 3 cycles.
// - Out of range (ADDR_W=10): read addr=0x1000 -> ready with err=1, rdata keeps its prior value.
//   - Write 0x1000 with wdata=0x5 -> RAM[0] is unchanged.
// - Simultaneous rise of readdmem and writedmem at addr=0x20 -> err=1; a later read of 0x20
//   returns its old value.
// - Misaligned write addr=0x13, wdata=0x1234:
//   - With DMEM_ALIGN_CHK_EN -> err=1.
//   - Without it -> err=0, and a read of 0x10 returns 0x1234.
// - Reset drop (reset=0) during WAIT of a write to 0x40 -> outputs return to 0 immediately.
//   - A read of 0x40 after reset returns the pre-write contents.

Source files
------------

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Data-memory responder for the multi-cycle RISC core. The control FSM raises
// readdmem/writedmem (level strobes held for several cycles) in the MEM stage.
// This block turns a rising edge of either strobe into a single word access on
// an internal RAM. It inserts WAIT_CYC wait states before the access and then
// reports completion with a one-cycle ready pulse. err qualifies ready when the
// access was rejected.
//
// Parameters
//   ADDR_W    word-address width, DEPTH = 2**ADDR_W 32-bit words
//   WAIT_CYC  wait-state cycles before the access (0..15)
//
// Compile-time option
//   DMEM_ALIGN_CHK_EN  when defined, a byte address with addr[1:0] != 0 is
//                      rejected. When undefined, addr[1:0] is ignored.
//
// Ports
//   clk        in   system clock, all state changes on posedge
//   reset      in   asynchronous active-low reset
//   readdmem   in   read strobe (level)
//   writedmem  in   write strobe (level)
//   addr       in   32-bit byte address, word index = addr[ADDR_W+1:2]
//   wdata      in   32-bit store data
//   rdata      out  32-bit load data, held until the next successful read
//   ready      out  one-cycle completion pulse
//   busy       out  high while a transaction is in progress
//   err        out  high together with ready when the access was rejected
// -----------------------------------------------------------------------------
module data_mem_responder #(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        readdmem,
  input  logic        writedmem,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   wait_cnt;
  logic               rd_prev;
  logic               wr_prev;
  logic               op_write;
  logic [ADDR_W-1:0]  idx_reg;
  logic [31:0]        wdata_reg;
  logic               bad_reg;

  logic [31:0]        mem [DEPTH];

  logic               req;
  logic               both_rise;
  logic               out_of_range;
  logic               misaligned;
  logic               req_bad;
  logic               mem_we;

  // The request is the rising edge of the combined strobe. A strobe that stays
  // high therefore never starts a second transaction.
  assign req = (readdmem | writedmem) & ~(rd_prev | wr_prev);

  // A request needs both previous strobe values low. If both strobes are high
  // now, they rose on the same edge.
  assign both_rise = readdmem & writedmem;

  // Any address bit above the word index selects a word beyond DEPTH.
  assign out_of_range = (addr >> (ADDR_W + 2)) != 32'd0;

`ifdef DMEM_ALIGN_CHK_EN
  assign misaligned = addr[1:0] != 2'b00;
`else
  assign misaligned = 1'b0;
`endif

  assign req_bad = both_rise | out_of_range | misaligned;

  // The RAM is not reset. After a reset the FSM sits in IDLE, so a write that
  // was still waiting for its access is never committed.
  assign mem_we = (state == S_ACCESS) && op_write && !bad_reg;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_reg] <= wdata_reg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      rd_prev   <= 1'b0;
      wr_prev   <= 1'b0;
      op_write  <= 1'b0;
      idx_reg   <= '0;
      wdata_reg <= '0;
      bad_reg   <= 1'b0;
      rdata     <= '0;
      ready     <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      // The strobe history updates every cycle. A strobe still held when the
      // FSM returns to IDLE does not look like a fresh edge.
      rd_prev <= readdmem;
      wr_prev <= writedmem;
      ready   <= 1'b0;
      err     <= 1'b0;

      case (state)
        S_IDLE: begin
          if (req) begin
            op_write  <= writedmem;
            idx_reg   <= addr[ADDR_W+1:2];
            wdata_reg <= wdata;
            bad_reg   <= req_bad;
            busy      <= 1'b1;
            if (WAIT_CYC == 0) begin
              state <= S_ACCESS;
            end else begin
              state    <= S_WAIT;
              wait_cnt <= WAIT_INIT;
            end
          end
        end

        S_WAIT: begin
          if (wait_cnt == '0) begin
            state <= S_ACCESS;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        S_ACCESS: begin
          // ready is high during DONE. A rejected access keeps the same
          // timing, but it leaves rdata and the RAM untouched.
          ready <= 1'b1;
          err   <= bad_reg;
          if (!op_write && !bad_reg) begin
            rdata <= mem[idx_reg];
          end
          state <= S_DONE;
        end

        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
